// File: rtl/lu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lu_pkg
// Description : Shared opcodes, FSM state encoding and default width for the
//               logic-unit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package lu_pkg;

    localparam int unsigned LU_DEFAULT_WIDTH = 8;

    // {s1,s0} selects of the shared logic unit
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NOTA = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker: first set request at or
//               above ptr, wrapping; returns one-hot grant, index and any.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW:0] w_sum;

    // Explicit compare-and-subtract keeps the wrap correct for any NREQ.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        w_sum = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, ptr} + (IDW+1)'(i);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            if (!any && req[w_sum[IDW-1:0]]) begin
                any = 1'b1;
                idx = w_sum[IDW-1:0];
            end
        end
        gnt[idx] = any;
    end

endmodule
`default_nettype wire

// File: rtl/lu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lu_arbiter
// Description : Round-robin arbiter/sequencer sharing one logic unit among
//               NREQ requesters, with a valid/ready response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module lu_arbiter
    import lu_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = LU_DEFAULT_WIDTH,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*2-1:0]     req_op,
    output logic [WIDTH-1:0]      lu_a,
    output logic [WIDTH-1:0]      lu_b,
    output logic                  lu_s1,
    output logic                  lu_s0,
    input  logic [WIDTH-1:0]      lu_d,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic [15:0]           ops_done
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_lu_a;
    logic [WIDTH-1:0] r_lu_b;
    logic [1:0]       r_lu_op;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [IDW-1:0]   r_rsp_id;
    logic [15:0]      r_ops_done;

    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_gnt_idx;
    logic             w_gnt_any;
    logic [IDW-1:0]   w_ptr_nxt;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req  (req_valid),
        .ptr  (r_rr_ptr),
        .gnt  (w_gnt),
        .idx  (w_gnt_idx),
        .any  (w_gnt_any)
    );

    assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + IDW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt_any) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (r_state == S_IDLE && !reset) begin
            req_ready = w_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_lu_a      <= '0;
            r_lu_b      <= '0;
            r_lu_op     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_ops_done  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        r_lu_a   <= req_a[w_gnt_idx*WIDTH +: WIDTH];
                        r_lu_b   <= req_b[w_gnt_idx*WIDTH +: WIDTH];
                        r_lu_op  <= req_op[w_gnt_idx*2 +: 2];
                        r_id     <= w_gnt_idx;
                        r_rr_ptr <= w_ptr_nxt;
                    end
                end
                S_EXEC: begin
                    r_rsp_data  <= lu_d;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_ops_done != 16'hFFFF) begin
                            r_ops_done <= r_ops_done + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign lu_a      = r_lu_a;
    assign lu_b      = r_lu_b;
    assign lu_s1     = r_lu_op[1];
    assign lu_s0     = r_lu_op[0];
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign ops_done  = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_lu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lu_arbiter
// Description : Self-checking bench for lu_arbiter with a logic-unit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lu_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [N*2-1:0]  req_op;
    logic [W-1:0]    lu_a, lu_b, lu_d, rsp_data;
    logic            lu_s1, lu_s0, rsp_valid, rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [15:0]     ops_done;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_ptr  = 0;
    int m_ops  = 0;
    int last_g = -1;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [5];

    function automatic logic [7:0] lu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    function automatic int rr_model(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    always #5 clk = ~clk;

    always_comb lu_d = lu_fn(lu_a, lu_b, {lu_s1, lu_s0});

    lu_arbiter #(
        .NREQ  (N),
        .WIDTH (W),
        .IDW   (IW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .lu_a      (lu_a),
        .lu_b      (lu_b),
        .lu_s1     (lu_s1),
        .lu_s0     (lu_s0),
        .lu_d      (lu_d),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .ops_done  (ops_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One full transaction: grant, exec, optional backpressure, accept.
    task automatic do_op(input logic [N-1:0] v, input int g, input logic [7:0] d, input int bp);
        logic [7:0]    hd;
        logic [IW-1:0] hid;
        req_valid = v;
        #1;
        chk("grant", 32'(req_ready), 32'(1 << g));
        if ($countones(v) > 1 && last_g >= 0) begin
            chk("rr_no_repeat", 32'(req_ready[last_g]), 32'd0);
        end
        step();
        last_g = g;
        m_ptr  = (g + 1) % N;
        chk("lu_a", 32'(lu_a), 32'(req_a[g*W +: W]));
        chk("lu_b", 32'(lu_b), 32'(req_b[g*W +: W]));
        chk("lu_sel", 32'({lu_s1, lu_s0}), 32'(req_op[2*g +: 2]));
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("exec_req_ready", 32'(req_ready), 32'd0);
        step();
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_data", 32'(rsp_data), 32'(d));
        chk("rsp_id", 32'(rsp_id), 32'(g));
        chk("resp_req_ready", 32'(req_ready), 32'd0);
        hd  = rsp_data;
        hid = rsp_id;
        for (int k = 0; k < bp; k++) begin
            step();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", 32'(rsp_data), 32'(hd));
            chk("bp_id", 32'(rsp_id), 32'(hid));
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_ops_done", 32'(ops_done), 32'(m_ops));
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        m_ops++;
        chk("accept_valid", 32'(rsp_valid), 32'd0);
        chk("ops_done", 32'(ops_done), 32'(m_ops));
    endtask

    initial begin
        logic [N-1:0] v;
        int           g;

        tbl[0] = '{0, 8'hF0, 8'h3C, 2'b00, 8'h30};
        tbl[1] = '{2, 8'hA5, 8'h0F, 2'b00, 8'h05};
        tbl[2] = '{2, 8'hA5, 8'h0F, 2'b01, 8'hAF};
        tbl[3] = '{2, 8'hA5, 8'h0F, 2'b10, 8'hAA};
        tbl[4] = '{2, 8'hA5, 8'h0F, 2'b11, 8'h5A};

        reset     = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ops_done", 32'(ops_done), 32'd0);
        chk("rst_lu", 32'({lu_a, lu_b, lu_s1, lu_s0}), 32'd0);
        chk("rst_rsp", 32'({rsp_data, rsp_id}), 32'd0);
        req_valid = '0;
        reset     = 1'b0;
        step();
        chk("idle_no_ready", 32'(req_ready), 32'd0);

        foreach (tbl[i]) begin
            req_a[tbl[i].id*W +: W]  = tbl[i].a;
            req_b[tbl[i].id*W +: W]  = tbl[i].b;
            req_op[tbl[i].id*2 +: 2] = tbl[i].op;
            do_op(N'(1) << tbl[i].id, tbl[i].id, tbl[i].exp, 0);
        end

        // All requesters held valid: strict rotation from the current pointer.
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W]  = 8'(8'h11 * (i + 1));
            req_b[i*W +: W]  = 8'(8'h3C + i);
            req_op[i*2 +: 2] = 2'(i);
        end
        for (int i = 0; i < 8; i++) begin
            g = rr_model('1, m_ptr);
            do_op('1, g, lu_fn(req_a[g*W +: W], req_b[g*W +: W], req_op[g*2 +: 2]), 0);
        end

        g = rr_model('1, m_ptr);
        do_op('1, g, lu_fn(req_a[g*W +: W], req_b[g*W +: W], req_op[g*2 +: 2]), 5);

        // Pointer to 3, then only req1 valid forces a wrap; pointer then 2.
        do_op(4'b0100, 2, lu_fn(req_a[2*W +: W], req_b[2*W +: W], req_op[4 +: 2]), 0);
        do_op(4'b0010, 1, lu_fn(req_a[1*W +: W], req_b[1*W +: W], req_op[2 +: 2]), 0);
        do_op(4'b1111, 2, lu_fn(req_a[2*W +: W], req_b[2*W +: W], req_op[4 +: 2]), 0);

        for (int r = 0; r < 40; r++) begin
            req_a  = {$urandom, $urandom};
            req_b  = {$urandom, $urandom};
            req_op = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                req_valid = '0;
                #1;
                chk("rand_idle_ready", 32'(req_ready), 32'd0);
                step();
                chk("rand_idle_ops", 32'(ops_done), 32'(m_ops));
            end
            v = N'($urandom_range(1, 15));
            g = rr_model(v, m_ptr);
            do_op(v, g, lu_fn(req_a[g*W +: W], req_b[g*W +: W], req_op[g*2 +: 2]),
                  $urandom_range(0, 3));
        end

        // Reset while a response is pending.
        req_valid = 4'b1000;
        step();
        step();
        chk("midop_rsp_valid", 32'(rsp_valid), 32'd1);
        reset     = 1'b1;
        req_valid = '1;
        step();
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_ops_done", 32'(ops_done), 32'd0);
        chk("midrst_lu", 32'({lu_a, lu_b, lu_s1, lu_s0}), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        reset  = 1'b0;
        m_ptr  = 0;
        m_ops  = 0;
        last_g = -1;
        do_op('1, 0, lu_fn(req_a[0 +: W], req_b[0 +: W], req_op[0 +: 2]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
